candy_id: RTL

- Instruction decode stage; sits directly upstream of candy_regs.
- Each cycle it:
  - decodes the 24-bit instruction from fetch;
  - drives the two register-file read ports;
  - selects operands by forwarding EX/MEM results over rdata;
  - registers the decoded bundle into the ID/EX pipeline register.
- Detects load-use hazards, stalls fetch, inserts bubbles, honours branch flush, and counts stall cycles.

---
 rtl/candy_id_pkg.sv | 77 +++++++
 rtl/candy_id_fwd.sv | 30 +++
 rtl/candy_id.sv | 134 +++++++++++++
 3 files changed

// File: rtl/candy_id_pkg.sv
// Shared types and the instruction decoder for the candy ID stage.
package candy_id_pkg;

    localparam int unsigned InstW    = 24;
    localparam int unsigned RegW     = 24;
    localparam int unsigned RegAddrW = 4;
    localparam int unsigned OpW      = 3;

    typedef enum logic [5:0] {
        OpcNop  = 6'h00,
        OpcAdd  = 6'h01,
        OpcAddi = 6'h02,
        OpcLd   = 6'h03,
        OpcSt   = 6'h04,
        OpcBeq  = 6'h05,
        OpcLui  = 6'h06
    } opcode_e;

    typedef enum logic [OpW-1:0] {
        ClsNop  = 3'd0,
        ClsAdd  = 3'd1,
        ClsAddi = 3'd2,
        ClsLd   = 3'd3,
        ClsSt   = 3'd4,
        ClsBeq  = 3'd5,
        ClsLui  = 3'd6
    } op_cls_e;

    typedef struct packed {
        op_cls_e             op;
        logic [RegAddrW-1:0] rd;
        logic                we;
        logic                use1;
        logic [RegAddrW-1:0] rs1;
        logic                use2;
        logic [RegAddrW-1:0] rs2;
        logic [RegW-1:0]     imm;
        logic                illegal;
    } dec_t;

    typedef struct packed {
        logic            valid;
        op_cls_e         op;
        logic [RegAddrW-1:0] rd;
        logic            we;
        logic [RegW-1:0] src1;
        logic [RegW-1:0] src2;
        logic [RegW-1:0] imm;
        logic            illegal;
    } ex_t;

    function automatic dec_t decode(input logic [InstW-1:0] inst);
        dec_t d;
        d.op      = ClsNop;
        d.we      = 1'b0;
        d.use1    = 1'b0;
        d.use2    = 1'b0;
        d.rs1     = inst[13:10];
        d.rs2     = inst[9:6];
        d.imm     = {{14{inst[9]}}, inst[9:0]};
        d.illegal = 1'b0;
        case (inst[23:18])
            OpcNop:  d.op = ClsNop;
            OpcAdd:  begin d.op = ClsAdd;  d.we = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1; end
            OpcAddi: begin d.op = ClsAddi; d.we = 1'b1; d.use1 = 1'b1; end
            OpcLd:   begin d.op = ClsLd;   d.we = 1'b1; d.use1 = 1'b1; end
            // Stores and branches carry their second source in the rd slot.
            OpcSt:   begin d.op = ClsSt;  d.use1 = 1'b1; d.use2 = 1'b1; d.rs2 = inst[17:14]; end
            OpcBeq:  begin d.op = ClsBeq; d.use1 = 1'b1; d.use2 = 1'b1; d.rs2 = inst[17:14]; end
            OpcLui:  begin d.op = ClsLui; d.we = 1'b1; d.imm = {inst[9:0], 14'b0}; end
            default: d.illegal = 1'b1;
        endcase
        d.rd = d.we ? inst[17:14] : '0;
        return d;
    endfunction

endpackage

// File: rtl/candy_id_fwd.sv
// Operand select for one source: EX result, then MEM result, then register file.
module candy_id_fwd
    import candy_id_pkg::*;
(
    input  logic                use_i,
    input  logic [RegAddrW-1:0] addr_i,
    input  logic [RegW-1:0]     rdata_i,
    input  logic                ex_we_i,
    input  logic [RegAddrW-1:0] ex_waddr_i,
    input  logic [RegW-1:0]     ex_wdata_i,
    input  logic                mem_we_i,
    input  logic [RegAddrW-1:0] mem_waddr_i,
    input  logic [RegW-1:0]     mem_wdata_i,
    output logic [RegW-1:0]     data_o
);

    always_comb begin
        data_o = '0;
        if (!use_i) begin
            data_o = '0;
        end else if (ex_we_i && (ex_waddr_i == addr_i)) begin
            data_o = ex_wdata_i;
        end else if (mem_we_i && (mem_waddr_i == addr_i)) begin
            data_o = mem_wdata_i;
        end else begin
            data_o = rdata_i;
        end
    end

endmodule

// File: rtl/candy_id.sv
// Decode stage: decodes fetch output, reads/forwards operands, handles load-use
// stalls and flush, and registers the ID/EX bundle.
module candy_id
    import candy_id_pkg::*;
#(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    input  logic [InstW-1:0]    if_inst,
    input  logic [PC_W-1:0]     if_pc,
    input  logic                flush,
    output logic                re1,
    output logic [RegAddrW-1:0] raddr1,
    output logic                re2,
    output logic [RegAddrW-1:0] raddr2,
    input  logic [RegW-1:0]     rdata1,
    input  logic [RegW-1:0]     rdata2,
    input  logic                ex_fwd_we,
    input  logic [RegAddrW-1:0] ex_fwd_waddr,
    input  logic [RegW-1:0]     ex_fwd_wdata,
    input  logic                ex_fwd_is_load,
    input  logic                mem_fwd_we,
    input  logic [RegAddrW-1:0] mem_fwd_waddr,
    input  logic [RegW-1:0]     mem_fwd_wdata,
    output logic                id_stall,
    output logic                ex_valid,
    output logic [OpW-1:0]      ex_op,
    output logic [RegAddrW-1:0] ex_rd,
    output logic                ex_we,
    output logic [RegW-1:0]     ex_src1,
    output logic [RegW-1:0]     ex_src2,
    output logic [RegW-1:0]     ex_imm,
    output logic [PC_W-1:0]     ex_pc,
    output logic                ex_illegal,
    output logic [CNT_W-1:0]    stall_cnt
);

    dec_t             dec;
    ex_t              ex_d, ex_q;
    logic [PC_W-1:0]  pc_d, pc_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             stall_d, stall_q;
    logic [RegW-1:0]  src1, src2;
    logic             hit1, hit2;

    assign dec    = decode(if_inst);
    assign re1    = if_valid & dec.use1;
    assign re2    = if_valid & dec.use2;
    assign raddr1 = re1 ? dec.rs1 : '0;
    assign raddr2 = re2 ? dec.rs2 : '0;

    candy_id_fwd u_fwd1 (
        .use_i       (re1),
        .addr_i      (dec.rs1),
        .rdata_i     (rdata1),
        .ex_we_i     (ex_fwd_we),
        .ex_waddr_i  (ex_fwd_waddr),
        .ex_wdata_i  (ex_fwd_wdata),
        .mem_we_i    (mem_fwd_we),
        .mem_waddr_i (mem_fwd_waddr),
        .mem_wdata_i (mem_fwd_wdata),
        .data_o      (src1)
    );

    candy_id_fwd u_fwd2 (
        .use_i       (re2),
        .addr_i      (dec.rs2),
        .rdata_i     (rdata2),
        .ex_we_i     (ex_fwd_we),
        .ex_waddr_i  (ex_fwd_waddr),
        .ex_wdata_i  (ex_fwd_wdata),
        .mem_we_i    (mem_fwd_we),
        .mem_waddr_i (mem_fwd_waddr),
        .mem_wdata_i (mem_fwd_wdata),
        .data_o      (src2)
    );

    // A load-use hazard stalls once; stall_q marks that the bubble is already in EX.
    assign hit1     = re1 && (ex_fwd_waddr == dec.rs1);
    assign hit2     = re2 && (ex_fwd_waddr == dec.rs2);
    assign id_stall = ex_fwd_is_load && ex_fwd_we && (hit1 || hit2) && !flush && !stall_q;

    always_comb begin
        ex_d    = ex_q;
        pc_d    = pc_q;
        stall_d = id_stall;
        cnt_d   = (id_stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        if (flush) begin
            ex_d.valid   = 1'b0;
            ex_d.illegal = 1'b0;
        end else if (id_stall) begin
            ex_d.valid = 1'b0;
        end else begin
            ex_d.valid   = if_valid;
            ex_d.op      = dec.op;
            ex_d.rd      = dec.rd;
            ex_d.we      = dec.we;
            ex_d.src1    = src1;
            ex_d.src2    = src2;
            ex_d.imm     = dec.imm;
            ex_d.illegal = dec.illegal;
            pc_d         = if_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            ex_q    <= ex_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_op      = ex_q.op;
    assign ex_rd      = ex_q.rd;
    assign ex_we      = ex_q.we;
    assign ex_src1    = ex_q.src1;
    assign ex_src2    = ex_q.src2;
    assign ex_imm     = ex_q.imm;
    assign ex_pc      = pc_q;
    assign ex_illegal = ex_q.illegal;
    assign stall_cnt  = cnt_q;

endmodule
